// File: rtl/warp_pkg.sv
// warp_pkg: shared widths, requester IDs and arbiter state encoding for the warp accelerator.
package warp_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int MEM_REQ_FETCH = 0;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/rocc_mem_arbiter_if.sv
// rocc_mem_arbiter_if: requester-side and L1-side signals of the shared RoCC memory port.
interface rocc_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WIDTH = warp_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTSTANDING = 4
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0] req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0] resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic mem_req_valid;
    logic mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic mem_req_write;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic mem_resp_valid;
    logic mem_resp_ready;
    logic [DATA_WIDTH-1:0] mem_resp_data;
    logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding;
    logic err_orphan_resp;
    modport slave (
        input req_valid, req_addr, req_write, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, mem_req_write,
        output mem_req_data, mem_resp_ready, outstanding, err_orphan_resp
    );
    modport master (
        output req_valid, req_addr, req_write, req_wdata, mem_req_ready, mem_resp_valid, mem_resp_data,
        input req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, mem_req_write,
        input mem_req_data, mem_resp_ready, outstanding, err_orphan_resp
    );
endinterface

// File: rtl/warp_id_fifo.sv
// warp_id_fifo: synchronous FIFO, DEPTH a power of two; no push/pop bypass.
module warp_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_comb begin
        full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
        empty = wr_q == rd_q;
        count = wr_q - rd_q;
        dout = mem_q[rd_q[AW-1:0]];
        wr_d = (push && !full) ? wr_q + 1'b1 : wr_q;
        rd_d = (pop && !empty) ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rocc_mem_arbiter.sv
// rocc_mem_arbiter: round-robin share of the RoCC L1 port; in-order ID FIFO routes responses back.
module rocc_mem_arbiter
    import warp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WIDTH = warp_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic clk,
    input logic rst,
    rocc_mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_e state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick, grant, head;
    logic err_q, err_d, found, accept, pop, full, empty;
    always_comb begin
        found = 1'b0;
        pick = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
        grant = (state_q == ARB_LOCKED) ? grant_q : pick;
        // A full FIFO blocks new grants; a lock can only exist while not full.
        bus.mem_req_valid = !rst && !full && (state_q == ARB_LOCKED || found);
        bus.mem_req_addr = bus.req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_req_data = bus.req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        bus.mem_req_write = bus.req_write[grant];
        accept = bus.mem_req_valid && bus.mem_req_ready;
        bus.req_ready = accept ? NUM_REQ'(1) << grant : '0;
        state_d = accept ? ARB_IDLE : (bus.mem_req_valid ? ARB_LOCKED : state_q);
        grant_d = grant;
        rr_ptr_d = accept ? ((int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1) : rr_ptr_q;
        pop = !rst && bus.mem_resp_valid && !empty;
        bus.resp_valid = pop ? NUM_REQ'(1) << head : '0;
        bus.resp_data = bus.mem_resp_data;
        bus.mem_resp_ready = !rst;
        err_d = err_q || (bus.mem_resp_valid && empty);
        bus.err_orphan_resp = err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_ptr_q <= IW'(MEM_REQ_FETCH);
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q <= err_d;
        end
    end
    warp_id_fifo #(.WIDTH(IW), .DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk(clk),
        .rst(rst),
        .push(accept),
        .pop(pop),
        .din(grant),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(bus.outstanding)
    );
endmodule

// File: tb/tb_rocc_mem_arbiter.sv
// tb_rocc_mem_arbiter: scenario tasks with an ID scoreboard for rocc_mem_arbiter.
module tb_rocc_mem_arbiter;
    import warp_pkg::*;
    localparam int N = 4;
    localparam int AW = ADDR_WIDTH;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_err = 0;
    int sb_id[$];
    always #5 clk = ~clk;
    rocc_mem_arbiter_if bus ();
    rocc_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic logic [N-1:0] oh(int i);
        return N'(1) << i;
    endfunction
    task automatic clear_in;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        clear_in();
        step();
        step();
        rst = 1'b0;
        sb_id.delete();
    endtask
    task automatic drain(input int cnt, input logic [31:0] base);
        int e;
        for (int k = 0; k < cnt; k++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data = base + 32'(k);
            #2;
            e = (sb_id.size() > 0) ? sb_id.pop_front() : -1;
            n_cmp++;
            if (e < 0 || bus.resp_valid !== oh(e) || bus.resp_data !== base + 32'(k)) begin
                n_err++;
                $display("FAIL drain_resp%0d got %b/%h want id %0d/%h", k, bus.resp_valid, bus.resp_data, e, base + 32'(k));
            end
            step();
        end
        bus.mem_resp_valid = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        clear_in();
        step();
        #2;
        n_cmp++;
        if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== '0 || bus.resp_valid !== '0 ||
            bus.mem_resp_ready !== 1'b0 || bus.outstanding !== '0 || bus.err_orphan_resp !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got v%b rr%b rv%b mr%b o%0d e%b want all 0",
                     bus.mem_req_valid, bus.req_ready, bus.resp_valid, bus.mem_resp_ready, bus.outstanding, bus.err_orphan_resp);
        end
        step();
        rst = 1'b0;
        #2;
        n_cmp++;
        if (bus.mem_resp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_resp_ready got %b want 1", bus.mem_resp_ready);
        end
        step();
    endtask
    task automatic test_single_load;
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_addr[1*AW +: AW] = AW'(32'h100);
        bus.mem_req_ready = 1'b1;
        #2;
        n_cmp++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== AW'(32'h100) || bus.mem_req_write !== 1'b0 || bus.req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL single_req got v%b a%h w%b rr%b want 1/100/0/0010",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_write, bus.req_ready);
        end
        sb_id.push_back(1);
        step();
        clear_in();
        #2;
        n_cmp++;
        if (bus.outstanding !== 3'd1) begin
            n_err++;
            $display("FAIL single_outstanding got %0d want 1", bus.outstanding);
        end
        step();
        drain(1, 32'hDEADBEEF);
        #2;
        n_cmp++;
        if (bus.outstanding !== 3'd0) begin
            n_err++;
            $display("FAIL single_drained got %0d want 0", bus.outstanding);
        end
    endtask
    task automatic test_fairness;
        int e;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = AW'(32'h400 + 32'(i) * 32'h10);
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.mem_resp_valid = (k > 0);
            bus.mem_resp_data = 32'h1000 + 32'(k);
            #2;
            if (k > 0) begin
                e = (sb_id.size() > 0) ? sb_id.pop_front() : -1;
                n_cmp++;
                if (e < 0 || bus.resp_valid !== oh(e) || bus.resp_data !== 32'h1000 + 32'(k)) begin
                    n_err++;
                    $display("FAIL fair_resp%0d got %b want id %0d", k, bus.resp_valid, e);
                end
            end
            n_cmp++;
            if (bus.req_ready !== oh(k % N) || bus.mem_req_addr !== AW'(32'h400 + 32'(k % N) * 32'h10)) begin
                n_err++;
                $display("FAIL fair_grant%0d got %b/%h want %b", k, bus.req_ready, bus.mem_req_addr, oh(k % N));
            end
            sb_id.push_back(k % N);
            step();
        end
        clear_in();
        drain(1, 32'h2000);
        #2;
        n_cmp++;
        if (bus.outstanding !== 3'd0) begin
            n_err++;
            $display("FAIL fair_outstanding got %0d want 0", bus.outstanding);
        end
    endtask
    task automatic test_stall_lock;
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_addr[2*AW +: AW] = AW'(32'h200);
        bus.req_addr[1*AW +: AW] = AW'(32'h111);
        bus.req_addr[3*AW +: AW] = AW'(32'h333);
        for (int k = 0; k < 3; k++) begin
            #2;
            n_cmp++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== AW'(32'h200) || bus.req_ready !== '0) begin
                n_err++;
                $display("FAIL stall_hold%0d got v%b a%h rr%b want 1/200/0000", k, bus.mem_req_valid, bus.mem_req_addr, bus.req_ready);
            end
            step();
            bus.req_valid = 4'b0110;
        end
        bus.mem_req_ready = 1'b1;
        #2;
        n_cmp++;
        if (bus.req_ready !== 4'b0100 || bus.mem_req_addr !== AW'(32'h200)) begin
            n_err++;
            $display("FAIL stall_accept got %b/%h want 0100/200", bus.req_ready, bus.mem_req_addr);
        end
        sb_id.push_back(2);
        step();
        bus.req_valid = 4'b1010;
        #2;
        n_cmp++;
        if (bus.req_ready !== 4'b1000 || bus.mem_req_addr !== AW'(32'h333)) begin
            n_err++;
            $display("FAIL stall_next3 got %b/%h want 1000/333", bus.req_ready, bus.mem_req_addr);
        end
        sb_id.push_back(3);
        step();
        bus.req_valid = 4'b0010;
        #2;
        n_cmp++;
        if (bus.req_ready !== 4'b0010 || bus.mem_req_addr !== AW'(32'h111)) begin
            n_err++;
            $display("FAIL stall_next1 got %b/%h want 0010/111", bus.req_ready, bus.mem_req_addr);
        end
        sb_id.push_back(1);
        step();
        clear_in();
        drain(3, 32'h3000);
    endtask
    task automatic test_full;
        int e;
        do_reset();
        bus.req_valid = 4'b0001;
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req_addr[0 +: AW] = AW'(32'h40 * 32'(k));
            #2;
            n_cmp++;
            if (bus.req_ready !== 4'b0001) begin
                n_err++;
                $display("FAIL full_fill%0d got %b want 0001", k, bus.req_ready);
            end
            sb_id.push_back(0);
            step();
        end
        #2;
        n_cmp++;
        if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== '0 || bus.outstanding !== 3'd4) begin
            n_err++;
            $display("FAIL full_block got v%b rr%b o%0d want 0/0000/4", bus.mem_req_valid, bus.req_ready, bus.outstanding);
        end
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h55;
        #2;
        e = (sb_id.size() > 0) ? sb_id.pop_front() : -1;
        n_cmp++;
        if (bus.mem_req_valid !== 1'b0 || e < 0 || bus.resp_valid !== oh(e)) begin
            n_err++;
            $display("FAIL full_nobypass got v%b rv%b want 0/%b", bus.mem_req_valid, bus.resp_valid, oh(e));
        end
        step();
        bus.mem_resp_valid = 1'b0;
        #2;
        n_cmp++;
        if (bus.req_ready !== 4'b0001 || bus.outstanding !== 3'd3) begin
            n_err++;
            $display("FAIL full_refill got rr%b o%0d want 0001/3", bus.req_ready, bus.outstanding);
        end
        sb_id.push_back(0);
        step();
        clear_in();
        drain(4, 32'h4000);
    endtask
    task automatic test_ordering;
        int order[3] = '{3, 1, 2};
        do_reset();
        bus.mem_req_ready = 1'b1;
        foreach (order[k]) begin
            bus.req_valid = oh(order[k]);
            #2;
            n_cmp++;
            if (bus.req_ready !== oh(order[k])) begin
                n_err++;
                $display("FAIL order_accept%0d got %b want %b", k, bus.req_ready, oh(order[k]));
            end
            sb_id.push_back(order[k]);
            step();
        end
        clear_in();
        drain(3, 32'hA0);
    endtask
    task automatic test_orphan;
        do_reset();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'hBAD;
        #2;
        n_cmp++;
        if (bus.resp_valid !== '0 || bus.mem_resp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL orphan_drop got rv%b mr%b want 0000/1", bus.resp_valid, bus.mem_resp_ready);
        end
        step();
        clear_in();
        #2;
        n_cmp++;
        if (bus.err_orphan_resp !== 1'b1) begin
            n_err++;
            $display("FAIL orphan_set got %b want 1", bus.err_orphan_resp);
        end
        step();
        step();
        bus.mem_req_ready = 1'b1;
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = 4'b0010;
        step();
        clear_in();
        #2;
        n_cmp++;
        if (bus.err_orphan_resp !== 1'b1 || bus.outstanding !== 3'd2) begin
            n_err++;
            $display("FAIL orphan_sticky got e%b o%0d want 1/2", bus.err_orphan_resp, bus.outstanding);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_id.delete();
        #2;
        n_cmp++;
        if (bus.outstanding !== 3'd0 || bus.err_orphan_resp !== 1'b0) begin
            n_err++;
            $display("FAIL orphan_rst got o%0d e%b want 0/0", bus.outstanding, bus.err_orphan_resp);
        end
        bus.mem_resp_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.resp_valid !== '0) begin
            n_err++;
            $display("FAIL orphan_after_rst got %b want 0000", bus.resp_valid);
        end
        step();
        clear_in();
        #2;
        n_cmp++;
        if (bus.err_orphan_resp !== 1'b1) begin
            n_err++;
            $display("FAIL orphan_reset_set got %b want 1", bus.err_orphan_resp);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_single_load();
        test_fairness();
        test_stall_lock();
        test_full();
        test_ordering();
        test_orphan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rocc_mem_arbiter.md
Name: rocc_mem_arbiter

Overview:
- Shares the single RoCC L1 memory port between NUM_REQ internal requesters (instruction fetch plus per-lane load/store units) using round-robin arbitration.
- Tracks outstanding requests in an in-order ID FIFO and routes each memory response back to the requester that issued it.
- Sits between the warp controller/lanes and the RoCC memory port pins of the accelerator top level.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is fetch, 1..NUM_REQ-1 are lanes.
- ADDR_WIDTH, warp_pkg::ADDR_WIDTH, memory address width.
- DATA_WIDTH, 32, request/response data width.
- MAX_OUTSTANDING, 4, ID FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_write  in  NUM_REQ  1 = store, 0 = load.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened store data.
- resp_valid  out  NUM_REQ  one-hot response strobe, single cycle; requesters always accept.
- resp_data  out  DATA_WIDTH  response data, broadcast to all requesters.
- mem_req_valid  out  1  to L1.
- mem_req_ready  in  1  from L1.
- mem_req_addr  out  ADDR_WIDTH  to L1.
- mem_req_write  out  1  to L1.
- mem_req_data  out  DATA_WIDTH  to L1.
- mem_resp_valid  in  1  from L1; exactly one response per request (loads and stores), in order.
- mem_resp_ready  out  1  to L1.
- mem_resp_data  in  DATA_WIDTH  from L1.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count.
- err_orphan_resp  out  1  sticky: a response arrived with no outstanding request.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - rr_ptr = 0, lock = 0, outstanding = 0, ID FIFO empty, err_orphan_resp = 0.
  - All outputs are 0: mem_req_valid, req_ready, resp_valid, mem_resp_ready.
- Arbiter states: ARB_IDLE (no grant held) and ARB_LOCKED (grant held, request not yet accepted).
- ARB_IDLE:
  - If the FIFO is not full and any req_valid is set, grant the first requester found scanning from rr_ptr upward with wrap-around.
  - Drive mem_req_* from the granted requester combinationally, in the same cycle.
  - If mem_req_ready is also high, the handshake completes this cycle; otherwise register the grant and go to ARB_LOCKED.
- ARB_LOCKED:
  - Keep the registered grant; mem_req_* continue to follow that requester.
  - Requesters must hold valid and payload stable until req_ready; the arbiter does not re-arbitrate.
  - Return to ARB_IDLE on mem_req_ready.
- Accept cycle (mem_req_valid && mem_req_ready):
  - req_ready[grant] = 1 in that cycle only.
  - Push the grant index into the ID FIFO.
  - rr_ptr <= (grant+1) mod NUM_REQ.
- Zero bubble: back-to-back grants to different requesters are possible on consecutive cycles.
- Full condition: with outstanding == MAX_OUTSTANDING, mem_req_valid = 0 and no new grant is made.
  - A pop in the same cycle does not free a slot until the next cycle (no bypass).
  - An already LOCKED grant is not reachable while full, because a lock requires an unaccepted valid, which requires not full.
- mem_resp_ready = 1 at all times, so orphan responses are always consumed.
- Response routing (mem_resp_valid):
  - FIFO non-empty: pop the head ID; resp_valid[head] = 1 and resp_data = mem_resp_data, combinationally in the same cycle.
  - FIFO empty: discard the response, set err_orphan_resp (cleared only by rst), resp_valid stays 0.
- Simultaneous push and pop: both occur and outstanding is unchanged.
  - With outstanding = 0, a request accepted in cycle N cannot be answered before N+1 (response returns after the FIFO write).
- Reset mid-transfer: all in-flight IDs are dropped; any later responses count as orphans.
- Widths: all indices are $clog2(NUM_REQ) bits; the FIFO pointers wrap modulo MAX_OUTSTANDING with an extra bit for full/empty detection.

Decomposition:
- Add to warp_pkg:
  - ARB_IDLE/ARB_LOCKED arbiter state enum (arb_state_e).
  - MEM_REQ_FETCH = 0 constant for requester IDs.
- Sub-module warp_id_fifo:
  - Synchronous FIFO parameterised by WIDTH and DEPTH.
  - Ports: push, pop, din, dout (head), full, empty, count.
  - Instantiated once as the outstanding-ID tracker.

Test Plan:
- Single load: req_valid=0010, addr 0x100, mem_req_ready=1 → mem_req_addr=0x100 the same cycle, req_ready=0010; mem_resp_data 0xDEADBEEF two cycles later → resp_valid=0010 with that data; outstanding back to 0.
- Fairness: all four requesters valid continuously, mem_req_ready=1 → grant order 0,1,2,3,0,1 on six consecutive cycles.
- Stall lock: requester 2 granted with mem_req_ready=0 for 3 cycles while requester 1 raises valid → grant stays 2 and addr stays stable; accept on cycle 4; requester 3 is granted next, then 1 (the scan after 2 finds 3 first).
- Full: 4 accepted requests with no responses → mem_req_valid=0 with requester 0 valid; one response → requester 0 accepted the following cycle, not the same cycle.
- Ordering: requests from 3,1,2 accepted, then 3 responses A,B,C → resp_valid sequence 1000 (A), 0010 (B), 0100 (C).
- Orphan: mem_resp_valid with outstanding=0 → resp_valid=0, err_orphan_resp=1, held until rst; rst asserted with 2 in flight → outstanding=0 the next cycle.
